// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS R-type core, its ALU and the instruction issuer.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_MEMWAIT,
    ST_SETTLE,
    ST_OUTPUT,
    ST_DONE
  } state_t;

  localparam logic [5:0]  OPCODE_RTYPE = 6'h00;
  localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;

  // Instruction field slice positions
  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  // Settle counter width; covers SETTLE_CYC up to 15
  localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/mips_settle_timer.sv
// Load-and-count-down timer that paces sampling of the combinational core result.
module mips_settle_timer
  import mips_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [SETTLE_CNT_W-1:0] load_val,
  input  logic                    en,
  output logic                    zero_c
);

  logic [SETTLE_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - SETTLE_CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mips_instr_issuer.sv
// Sequential front end: fetches instruction words, presents them to the core one at a
// time and streams the captured results out through a valid/ready handshake.
module mips_instr_issuer
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [31:0] HALT_WORD  = mips_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W:0]   max_count,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       core_instr,
  input  logic [31:0]       core_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [ADDR_W-1:0] res_pc,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   issued_count
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYC - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [ADDR_W-1:0] imem_addr_d, res_pc_d;
  logic [ADDR_W:0]   issued_d, issued_inc;
  logic [31:0]       core_instr_d, res_data_d;
  logic              res_valid_d, imem_rd_en_d, busy_d, done_d;
  logic              tmr_load, tmr_en, tmr_zero;

  mips_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .zero_c   (tmr_zero)
  );

  assign issued_inc = issued_count + (ADDR_W+1)'(1);

  // Next-state and next-register values
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    issued_d     = issued_count;
    core_instr_d = core_instr;
    res_data_d   = res_data;
    res_pc_d     = res_pc;
    res_valid_d  = res_valid;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_d     = start_pc;
          issued_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_MEMWAIT;
      ST_MEMWAIT: begin
        if (imem_rdata == HALT_WORD) begin
          state_d = ST_DONE;
        end else begin
          core_instr_d = imem_rdata;
          tmr_load     = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          res_data_d  = core_result;
          res_pc_d    = pc;
          res_valid_d = 1'b1;
          state_d     = ST_OUTPUT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (res_valid && res_ready) begin
          res_valid_d = 1'b0;
          issued_d    = issued_inc;
          pc_d        = pc + ADDR_W'(1);
          // Full-width compare so a budget of 2^ADDR_W is reachable
          if ((max_count != '0) && (issued_inc == max_count)) state_d = ST_DONE;
          else                                                state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    imem_rd_en_d = (state_d == ST_FETCH);
    imem_addr_d  = (state_d == ST_FETCH) ? pc_d : imem_addr;
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pc           <= '0;
      imem_rd_en   <= 1'b0;
      imem_addr    <= '0;
      core_instr   <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_pc       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      imem_rd_en   <= imem_rd_en_d;
      imem_addr    <= imem_addr_d;
      core_instr   <= core_instr_d;
      res_valid    <= res_valid_d;
      res_data     <= res_data_d;
      res_pc       <= res_pc_d;
      busy         <= busy_d;
      done         <= done_d;
      issued_count <= issued_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_issuer.sv
// Self-checking bench for mips_instr_issuer: vector table, directed corner cases and
// randomized runs scored against a run-level reference model.
module tb_mips_instr_issuer;
  import mips_pkg::*;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n, start, imem_rd_en, res_valid, res_ready, busy, done;
  logic [AW-1:0] start_pc, imem_addr, res_pc;
  logic [AW:0]   max_count, issued_count;
  logic [31:0]   imem_rdata, core_instr, core_result, res_data;

  logic [31:0]   mem [256];
  int            total = 0;
  int            bad = 0;
  bit            mon_on = 1'b0;

  logic [AW-1:0] got_pc[$], exp_pc[$], got_rd[$], exp_rd[$];
  logic [31:0]   got_data[$], exp_data[$];

  typedef struct {
    logic [AW-1:0] spc;
    logic [AW:0]   mc;
    int            halt_off;
    int            exp_n;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mips_instr_issuer #(.ADDR_W(AW), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .max_count(max_count),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .core_instr(core_instr), .core_result(core_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_pc(res_pc), .busy(busy),
    .done(done), .issued_count(issued_count)
  );

  function automatic logic [31:0] core_fn(input logic [31:0] w);
    if (w == 32'h0022_1820) return 32'h0000_0007;
    return {w[15:0], w[31:16]} ^ 32'h1234_5678;
  endfunction

  assign core_result = core_fn(core_instr);

  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  always @(negedge clk) begin
    if (mon_on) begin
      if (res_valid && res_ready) begin
        got_pc.push_back(res_pc);
        got_data.push_back(res_data);
      end
      if (imem_rd_en) got_rd.push_back(imem_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (w == HALT_WORD) w = 32'h0;
    return w;
  endfunction

  task automatic fill_mem(input logic [AW-1:0] spc, input int halt_off);
    logic [AW-1:0] hp;
    for (int i = 0; i < 256; i++) mem[i] = rand_word();
    if (halt_off >= 0) begin
      hp = spc + AW'(halt_off);
      mem[hp] = HALT_WORD;
    end
  endtask

  // Run-level model: walk memory from spc until the budget or a halt word
  task automatic model(input logic [AW-1:0] spc, input logic [AW:0] mc);
    logic [AW-1:0] pc = spc;
    int k = 0;
    exp_pc.delete(); exp_data.delete(); exp_rd.delete();
    got_pc.delete(); got_data.delete(); got_rd.delete();
    for (int it = 0; it < 600; it++) begin
      if (mc != 0 && k == int'(mc)) break;
      exp_rd.push_back(pc);
      if (mem[pc] == HALT_WORD) break;
      exp_pc.push_back(pc);
      exp_data.push_back(core_fn(mem[pc]));
      k++;
      pc = pc + 1'b1;
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] spc, input logic [AW:0] mc);
    start = 1'b1; start_pc = spc; max_count = mc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input string tag);
    int n = 0;
    while (!done && n < 4000) begin
      res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    res_ready = 1'b1;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, " nres"}, got_pc.size(), exp_pc.size());
    n = (got_pc.size() < exp_pc.size()) ? got_pc.size() : exp_pc.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s res_pc[%0d]", tag, i), 32'(got_pc[i]), 32'(exp_pc[i]));
      check($sformatf("%s res_data[%0d]", tag, i), got_data[i], exp_data[i]);
    end
    check({tag, " nreads"}, got_rd.size(), exp_rd.size());
    n = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s rd_addr[%0d]", tag, i), 32'(got_rd[i]), 32'(exp_rd[i]));
    check({tag, " issued_count"}, 32'(issued_count), exp_pc.size());
  endtask

  task automatic run(input logic [AW-1:0] spc, input logic [AW:0] mc, input bit rnd,
                     input string tag);
    model(spc, mc);
    mon_on = 1'b1;
    pulse_start(spc, mc);
    wait_done(rnd, tag);
    mon_on = 1'b0;
    compare(tag);
  endtask

  initial begin
    int c;
    bit stable, quiet;
    logic [31:0] hd;
    logic [AW-1:0] hp;

    vecs[0] = '{spc: 8'h00, mc: 9'd2,   halt_off: -1, exp_n: 2};   // budget stop
    vecs[1] = '{spc: 8'hFE, mc: 9'd0,   halt_off: 3,  exp_n: 3};   // pc wrap
    vecs[2] = '{spc: 8'h0A, mc: 9'd0,   halt_off: 0,  exp_n: 0};   // immediate halt
    vecs[3] = '{spc: 8'h14, mc: 9'd5,   halt_off: 2,  exp_n: 2};   // halt before budget
    vecs[4] = '{spc: 8'hFA, mc: 9'd0,   halt_off: 9,  exp_n: 9};
    vecs[5] = '{spc: 8'h1E, mc: 9'd4,   halt_off: 4,  exp_n: 4};   // budget hits first
    vecs[6] = '{spc: 8'h07, mc: 9'd256, halt_off: -1, exp_n: 256}; // full-width budget
    vecs[7] = '{spc: 8'h64, mc: 9'd1,   halt_off: -1, exp_n: 1};

    rst_n = 1'b0; start = 1'b0; start_pc = '0; max_count = '0; res_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset res_valid", 32'(res_valid), 0);
    check("reset rd_en", 32'(imem_rd_en), 0);
    check("reset core_instr", core_instr, 0);
    check("reset issued", 32'(issued_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single instruction with first-result latency
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h0022_1820;
    mem[5] = HALT_WORD;
    model(8'd4, 9'd0);
    mon_on = 1'b1;
    pulse_start(8'd4, 9'd0);
    c = 1;
    while (!res_valid && c < 20) begin @(posedge clk); #1; c++; end
    check("single latency", c, 5);
    check("single res_data", res_data, 32'h7);
    check("single res_pc", 32'(res_pc), 32'd4);
    wait_done(1'b0, "single");
    mon_on = 1'b0;
    compare("single");
    check("single issued", 32'(issued_count), 1);

    // Vector table
    foreach (vecs[v]) begin
      fill_mem(vecs[v].spc, vecs[v].halt_off);
      run(vecs[v].spc, vecs[v].mc, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d count", v), 32'(issued_count), vecs[v].exp_n);
    end

    // Backpressure during OUTPUT
    fill_mem(8'd40, 2);
    model(8'd40, 9'd0);
    mon_on = 1'b1;
    res_ready = 1'b0;
    start = 1'b1; start_pc = 8'd40; max_count = '0;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!res_valid && c < 20) begin @(posedge clk); #1; c++; end
    check("bp valid seen", 32'(res_valid), 1);
    hd = res_data; hp = res_pc;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!res_valid || res_data !== hd || res_pc !== hp || imem_rd_en) stable = 1'b0;
    end
    check("bp hold stable", 32'(stable), 1);
    check("bp no result yet", got_pc.size(), 0);
    wait_done(1'b0, "bp");
    mon_on = 1'b0;
    compare("bp");

    // start while busy is ignored
    fill_mem(8'd60, 2);
    model(8'd60, 9'd0);
    mon_on = 1'b1;
    pulse_start(8'd60, 9'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_start(8'd100, 9'd0);
    wait_done(1'b0, "busystart");
    mon_on = 1'b0;
    compare("busystart");

    // Reset mid-run while in SETTLE
    fill_mem(8'd50, -1);
    pulse_start(8'd50, 9'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid res_valid pre", 32'(res_valid), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid busy", 32'(busy), 0);
    check("mid done", 32'(done), 0);
    check("mid res_valid", 32'(res_valid), 0);
    check("mid res_data", res_data, 0);
    check("mid res_pc", 32'(res_pc), 0);
    check("mid core_instr", core_instr, 0);
    check("mid rd_en", 32'(imem_rd_en), 0);
    check("mid addr", 32'(imem_addr), 0);
    check("mid issued", 32'(issued_count), 0);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy || imem_rd_en) quiet = 1'b0;
    end
    check("mid quiet after reset", 32'(quiet), 1);

    // Randomized runs with random backpressure
    for (int r = 0; r < 10; r++) begin
      logic [AW-1:0] spc = AW'($urandom);
      logic [AW:0]   mc  = (AW+1)'($urandom_range(0, 12));
      fill_mem(spc, $urandom_range(0, 15));
      run(spc, mc, 1'b1, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_instr_issuer.md
Name: mips_instr_issuer

Overview:
- Sequential front end for the combinational MIPS R-type core: fetches 32-bit instruction words from an instruction memory, presents one at a time on the core's instruction input, and captures the core's result for each.
- Sits between the instruction ROM/RAM and the core. Provides PC sequencing, a valid/ready issue handshake, and a result output stream.
- Replaces ad-hoc testbench driving of the core's instruction input.

Parameters:
- ADDR_W, 8, instruction memory word-address width; PC wraps modulo 2^ADDR_W.
- SETTLE_CYC, 2, cycles the instruction is held before the result is sampled (core combinational settle time); legal range 1..15.
- HALT_WORD, 32'hFFFF_FFFF, sentinel instruction that ends a run.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run at start_pc. Ignored unless in IDLE or DONE.
- start_pc  in  ADDR_W  first word address of the run.
- max_count  in  ADDR_W+1  instruction budget; 0 means unlimited (run until HALT_WORD).
- imem_rd_en  out  1  memory read strobe.
- imem_addr  out  ADDR_W  memory word address.
- imem_rdata  in  32  read data, valid exactly 1 cycle after imem_rd_en.
- core_instr  out  32  instruction presented to the core.
- core_result  in  32  core result (combinational function of core_instr).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  32  captured result.
- res_pc  out  ADDR_W  PC of the instruction that produced res_data.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- issued_count  out  ADDR_W+1  instructions completed in the current run.

Behaviour:
- Reset (rst_n=0 at the edge) forces all of the following, regardless of current state (including a mid-run reset):
  - state=IDLE, pc=0, imem_rd_en=0, imem_addr=0, core_instr=0, res_valid=0, res_data=0, res_pc=0, busy=0, done=0, issued_count=0, settle counter=0.
- States: IDLE, FETCH, MEMWAIT, SETTLE, OUTPUT, DONE.
- IDLE/DONE + start=1:
  - pc<=start_pc, issued_count<=0, done<=0, next state FETCH.
- FETCH:
  - imem_rd_en=1, imem_addr=pc for exactly one cycle; next state MEMWAIT.
- MEMWAIT:
  - imem_rdata is valid here.
  - If imem_rdata==HALT_WORD: go to DONE; the sentinel is not issued and not counted.
  - Otherwise: core_instr<=imem_rdata, settle counter<=SETTLE_CYC-1, next state SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - When counter==0: res_data<=core_result, res_pc<=pc, res_valid<=1, next state OUTPUT.
- OUTPUT:
  - res_valid held high; res_data and res_pc held stable until res_valid && res_ready.
  - On handshake:
    - res_valid<=0, issued_count<=issued_count+1, pc<=pc+1 (wraps).
    - If max_count!=0 and issued_count+1==max_count: go to DONE; else go to FETCH.
- core_instr holds the last issued instruction in all states until the next MEMWAIT load; reset clears it to 0.
- Latency, first result with res_ready held high: start accepted in cycle 0; res_valid first high in cycle 3+SETTLE_CYC. Steady-state throughput is one instruction per 3+SETTLE_CYC cycles.
- start while busy: ignored; no state change.
- PC wraps from 2^ADDR_W-1 to 0; wrap does not stop the run.
- Budget check: issued_count is compared against max_count at full width ADDR_W+1, so a budget of 2^ADDR_W is legal.

Decomposition:
- Shared package mips_pkg holds:
  - the state enum;
  - the OPCODE_RTYPE and HALT_WORD constants;
  - the instruction field slice positions (rs 25:21, rt 20:16, rd 15:11, shamt 10:6, funct 5:0), shared with the core and its ALU.
- One sub-module is natural: mips_settle_timer (load value, count down, zero flag).

Test Plan:
- Reset mid-run: pull rst_n low while in SETTLE, with res_valid=0 before the reset -> after one edge, all outputs are 0, state is IDLE, and no res_valid pulse appears.
- Single-instruction run:
  - Setup: imem[4]=32'h0022_1820 (add r3,r1,r2), imem[5]=HALT_WORD, core model returns 32'h0000_0007, start_pc=4, max_count=0, res_ready=1.
  - Required: one result with res_data=7 and res_pc=4, res_valid first high at cycle 5 (SETTLE_CYC=2); then done=1 and issued_count=1.
- Backpressure: hold res_ready=0 for 10 cycles during OUTPUT -> res_valid, res_data and res_pc stable the whole time; imem_rd_en=0 the whole time; exactly one result is counted after release.
- Budget stop: 3 non-halt words at addresses 0..2, max_count=2 -> exactly 2 results (res_pc 0 and 1); done=1; address 2 is never read.
- PC wrap: ADDR_W=8, start_pc=8'hFE, halt word at address 1 -> results carry res_pc FE, FF, 00; done after the read of address 1; issued_count=3.
- start while busy: pulse start with a different start_pc during SETTLE -> ignored; the run completes from the original PC.
